// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: multi-cycle MSB-first magnitude comparator.
// Compares DIGIT bits per cycle and stops at the first differing digit,
// reporting one-hot eq/lt/gt with a start/busy/done handshake.
// Optional macro SERIAL_CMP_SIGNED_EN: treat operands as two's-complement
// by flipping the sign bit at load (offset-binary), so the unsigned digit
// compare yields the signed ordering.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; flags hold the last result
// S_COMPARE  | busy; one digit pair compared per clock, MSB digit first
// S_DONE     | one-cycle done pulse; flags valid
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW   = NDIG * DIGIT;
  localparam int PAD  = PW - WIDTH;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    sa;
  logic [PW-1:0]    sb;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_ld;
  logic [WIDTH-1:0] b_ld;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             last_dig;

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_ld = a ^ SIGN_MASK;
  assign b_ld = b ^ SIGN_MASK;
`else
  assign a_ld = a;
  assign b_ld = b;
`endif

  assign a_dig    = sa[PW-1 -: DIGIT];
  assign b_dig    = sb[PW-1 -: DIGIT];
  assign last_dig = (cnt == LAST);

  // State register with asynchronous abort on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave COMPARE on the first differing digit or after the last one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COMPARE;
      S_COMPARE: if ((a_dig != b_dig) || last_dig) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_COMPARE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: operand shift registers, digit counter and result flags.
  // Padding zeros go at the LSB end so digit boundaries line up from the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
      eq  <= 1'b0;
      lt  <= 1'b0;
      gt  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= PW'(a_ld) << PAD;
            sb  <= PW'(b_ld) << PAD;
            cnt <= '0;
            eq  <= 1'b0;
            lt  <= 1'b0;
            gt  <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (a_dig > b_dig) begin
            gt <= 1'b1;
          end else if (a_dig < b_dig) begin
            lt <= 1'b1;
          end else if (last_dig) begin
            eq <= 1'b1;
          end else begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
